gate_tester: RTL and testbench
==============================

GATE_TESTER -- requirements
Module: gate_tester

Interface
REQ-001 The parameter SETTLE_CYCLES SHALL default to 2 and set the number of extra cycles each vector is held before dut_c is sampled (legal range 0..15).
REQ-002 The parameter EXPECT SHALL default to 4'b1000 (AND) and give the expected dut_c per vector, where EXPECT[i] is the expected value for vector index i.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  request one exhaustive test run; sampled only in IDLE.
REQ-006 dut_a  output  1  gate input A driven to the device under test.
REQ-007 dut_b  output  1  gate input B driven to the device under test.
REQ-008 dut_c  input  1  gate output returned from the device under test.
REQ-009 busy  output  1  high from run start until the last sample.
REQ-010 done  output  1  one-cycle pulse marking the end of a run.
REQ-011 pass  output  1  the result of the last run: 1 when err_count is 0.
REQ-012 err_count  output  3  the number of mismatching vectors in the last run (0..4).
REQ-013 err_vec  output  2  the index of the first mismatching vector in the last run.

Function
REQ-014 The FSM SHALL use the states IDLE, HOLD and DONE, with transitions IDLE->HOLD on start, HOLD->DONE after vector 3 is sampled, and DONE->IDLE unconditionally after one cycle.
REQ-015 Vectors SHALL be applied in index order 0, 1, 2, 3 with dut_a = idx[1] and dut_b = idx[0], matching the sequence 00, 01, 10, 11.
REQ-016 Each vector SHALL be held for SETTLE_CYCLES+1 cycles, and dut_c SHALL be sampled on the final edge of that hold.
REQ-017 On the start-accept edge, the block SHALL clear err_count to 0, clear err_vec to 0, clear pass to 0, set busy to 1 and drive vector 0.
REQ-018 A sampled dut_c that differs from EXPECT[idx] SHALL increment err_count; err_vec SHALL capture idx only on the first mismatch of the run.
REQ-019 done SHALL rise exactly 4*(SETTLE_CYCLES+1)+1 edges after the start-accept edge and remain high for exactly one cycle.
REQ-020 busy SHALL fall on the same edge at which done rises.
REQ-021 pass SHALL be registered as (err_count==0) on the edge at which done rises, and SHALL be held until the next start is accepted.
REQ-022 err_count and err_vec SHALL hold their values until the next start is accepted.
REQ-023 start asserted while in HOLD or DONE SHALL be ignored without being queued; a start held high continuously SHALL launch a new run on the first IDLE cycle.
REQ-024 With SETTLE_CYCLES=0, each vector SHALL last one cycle and the run SHALL complete in 5 edges.
REQ-025 dut_a and dut_b SHALL be 0 whenever the FSM is in IDLE or DONE.

Reset
REQ-026 While rst_n is low at a clock edge, the FSM SHALL enter IDLE and all outputs SHALL be 0 (dut_a, dut_b, busy, done, pass, err_count, err_vec).
REQ-027 Reset asserted mid-run SHALL abort the run on that edge, with no done pulse and pass left at 0.
REQ-028 rst_n SHALL take priority over start on the same edge.

Structure
REQ-029 The package gate_tester_pkg SHALL hold the state enumeration (IDLE, HOLD, DONE), the constant NUM_VECTORS = 4 and the width constants for err_count and err_vec.
REQ-030 The hold timing SHALL be implemented in one sub-module, settle_counter, which loads on vector entry and flags terminal count at SETTLE_CYCLES.
REQ-031 The vector index, error capture and FSM SHALL reside in gate_tester itself.

Verification
REQ-032 Use the defaults with an ideal AND model on dut_c and pulse start once -> vectors 00, 01, 10, 11 each held 3 cycles; done rises 13 edges after accept; pass=1; err_count=0.
REQ-033 Use the defaults with an OR model on dut_c -> mismatches at vectors 1 and 2; err_count=2; err_vec=1; pass=0.
REQ-034 Set SETTLE_CYCLES=0 and EXPECT=4'b0110 with an XOR model -> done rises 5 edges after accept; pass=1.
REQ-035 Use the defaults and assert rst_n low at edge 6 of a run -> on that edge all outputs are 0 and the FSM is in IDLE; no done pulse occurs.
REQ-036 Use the defaults and pulse start during HOLD, then hold start high through DONE -> the mid-run pulse is ignored and a second run begins on the first IDLE cycle.
REQ-037 Drive dut_c to 0 for vector 3 only, then run again with the ideal AND model -> the first run gives err_count=1, err_vec=3; the second start clears both, ending with pass=1.

Source files
------------

// File: rtl/gate_tester_pkg.sv
// Shared types and constants for the two-input gate exhaustive tester.
package gate_tester_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned NUM_VECTORS = 4;
  localparam int unsigned IDX_W       = 2;
  localparam int unsigned ERR_CNT_W   = 3;
  localparam int unsigned ERR_VEC_W   = 2;
  localparam int unsigned SETTLE_W    = 4;

endpackage

// File: rtl/gate_tester_settle.sv
// Hold-time counter: restarts on vector entry, flags the final cycle of a hold.
module settle_counter
  import gate_tester_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_tc_c
);

  logic [SETTLE_W-1:0] r_cnt;

  assign o_tc_c = (r_cnt == SETTLE_W'(SETTLE_CYCLES));

  // Saturates at terminal count so an idle counter stays quiet.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (!o_tc_c) begin
      r_cnt <= r_cnt + SETTLE_W'(1);
    end
  end

endmodule

// File: rtl/gate_tester.sv
// Drives all four input combinations into a 2-input gate, compares its
// output against EXPECT and reports error count, first failing vector and pass.
module gate_tester
  import gate_tester_pkg::*;
#(
  parameter int unsigned              SETTLE_CYCLES = 2,
  parameter logic [NUM_VECTORS-1:0]   EXPECT        = 4'b1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 dut_a,
  output logic                 dut_b,
  input  logic                 dut_c,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ERR_VEC_W-1:0] err_vec
);

  state_t               r_state;
  state_t               w_next;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_dut_a;
  logic                 r_dut_b;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic [ERR_CNT_W-1:0] r_err_count;
  logic [ERR_VEC_W-1:0] r_err_vec;
  logic                 w_tc;
  logic                 w_accept;
  logic                 w_sample;
  logic                 w_last;
  logic                 w_mismatch;
  logic [IDX_W-1:0]     w_idx_next;

  settle_counter #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept | w_sample),
    .o_tc_c (w_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_next = HOLD;
      HOLD:    if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_accept = 1'b0;
    w_sample = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      IDLE: w_accept = start;
      HOLD: begin
        w_sample = w_tc;
        w_last   = w_tc && (r_idx == IDX_W'(NUM_VECTORS - 1));
      end
      default: ;
    endcase
  end

  assign w_mismatch = (dut_c != EXPECT[r_idx]);
  assign w_idx_next = r_idx + IDX_W'(1);

  // Vector drive, error capture and completion reporting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_dut_a     <= 1'b0;
      r_dut_b     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= '0;
      r_err_vec   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_idx       <= '0;
        r_dut_a     <= 1'b0;
        r_dut_b     <= 1'b0;
        r_busy      <= 1'b1;
        r_pass      <= 1'b0;
        r_err_count <= '0;
        r_err_vec   <= '0;
      end else if (w_sample) begin
        if (w_mismatch) begin
          r_err_count <= r_err_count + ERR_CNT_W'(1);
          if (r_err_count == '0) begin
            r_err_vec <= ERR_VEC_W'(r_idx);
          end
        end
        if (w_last) begin
          r_dut_a <= 1'b0;
          r_dut_b <= 1'b0;
        end else begin
          r_idx   <= w_idx_next;
          r_dut_a <= w_idx_next[1];
          r_dut_b <= w_idx_next[0];
        end
      end else if (r_state == DONE) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
        r_pass <= (r_err_count == '0);
      end
    end
  end

  assign dut_a     = r_dut_a;
  assign dut_b     = r_dut_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err_count;
  assign err_vec   = r_err_vec;

endmodule

// File: tb/tb_gate_tester.sv
// Directed bench for gate_tester: default AND build plus an XOR build with no settle time.
module tb_gate_tester;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       start_x;
  logic       dut_a, dut_b, dut_c;
  logic       dut_a_x, dut_b_x, dut_c_x;
  logic       busy, done, pass;
  logic       busy_x, done_x, pass_x;
  logic [2:0] err_count, err_count_x;
  logic [1:0] err_vec, err_vec_x;
  int         mode;
  int         errors;
  int         checks;

  gate_tester u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dut_a     (dut_a),
    .dut_b     (dut_b),
    .dut_c     (dut_c),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .err_vec   (err_vec)
  );

  gate_tester #(
    .SETTLE_CYCLES (0),
    .EXPECT        (4'b0110)
  ) u_dut_x (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_x),
    .dut_a     (dut_a_x),
    .dut_b     (dut_b_x),
    .dut_c     (dut_c_x),
    .busy      (busy_x),
    .done      (done_x),
    .pass      (pass_x),
    .err_count (err_count_x),
    .err_vec   (err_vec_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate models: 0 = AND, 1 = OR, 2 = AND with vector 3 stuck at 0.
  always_comb begin
    case (mode)
      1:       dut_c = dut_a | dut_b;
      2:       dut_c = 1'b0;
      default: dut_c = dut_a & dut_b;
    endcase
  end
  assign dut_c_x = dut_a_x ^ dut_b_x;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    start_x = 1'b1;
    tick();
    tick();
    checks++;
    if ({dut_a, dut_b, busy, done, pass, err_count, err_vec} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0",
               {dut_a, dut_b, busy, done, pass, err_count, err_vec});
    end
    checks++;
    if ({dut_a_x, dut_b_x, busy_x, done_x, pass_x, err_count_x, err_vec_x} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs_x: got %b want 0",
               {dut_a_x, dut_b_x, busy_x, done_x, pass_x, err_count_x, err_vec_x});
    end
    start = 1'b0;
    start_x = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: busy=%b want 0", busy);
    end
  endtask

  // One full run on the default build; vector k/3 is on the pins after edge k.
  task automatic run_default(input string name, input int exp_cnt, input int exp_vec,
                             input bit exp_pass);
    logic [3:0] exp_pins;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({dut_a, dut_b, busy, done, pass, err_count, err_vec} !== 10'b00_1_0_0_000_00) begin
      errors++;
      $display("FAIL %s_accept: got %b want 0010000000", name,
               {dut_a, dut_b, busy, done, pass, err_count, err_vec});
    end
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k < 12)       exp_pins = {2'(k / 3), 2'b10};
      else if (k == 12) exp_pins = 4'b0010;
      else              exp_pins = 4'b0001;
      checks++;
      if ({dut_a, dut_b, busy, done} !== exp_pins) begin
        errors++;
        $display("FAIL %s_edge%0d: a,b,busy,done=%b want %b", name, k,
                 {dut_a, dut_b, busy, done}, exp_pins);
      end
    end
    checks++;
    if ({pass, err_count, err_vec} !== {exp_pass, 3'(exp_cnt), 2'(exp_vec)}) begin
      errors++;
      $display("FAIL %s_result: pass,cnt,vec=%b,%0d,%0d want %b,%0d,%0d", name,
               pass, err_count, err_vec, exp_pass, exp_cnt, exp_vec);
    end
    tick();
    tick();
    checks++;
    if ({done, busy, pass, err_count, err_vec} !== {2'b00, exp_pass, 3'(exp_cnt), 2'(exp_vec)}) begin
      errors++;
      $display("FAIL %s_hold: done,busy,pass,cnt,vec=%b want %b", name,
               {done, busy, pass, err_count, err_vec},
               {2'b00, exp_pass, 3'(exp_cnt), 2'(exp_vec)});
    end
  endtask

  task automatic test_and();
    mode = 0;
    run_default("and", 0, 0, 1'b1);
  endtask

  task automatic test_or();
    mode = 1;
    run_default("or", 2, 1, 1'b0);
    mode = 0;
  endtask

  task automatic test_xor_fast();
    logic [3:0] exp_pins;
    start_x = 1'b1;
    tick();
    start_x = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k < 4)       exp_pins = {2'(k), 2'b10};
      else if (k == 4) exp_pins = 4'b0010;
      else             exp_pins = 4'b0001;
      checks++;
      if ({dut_a_x, dut_b_x, busy_x, done_x} !== exp_pins) begin
        errors++;
        $display("FAIL xor_edge%0d: a,b,busy,done=%b want %b", k,
                 {dut_a_x, dut_b_x, busy_x, done_x}, exp_pins);
      end
    end
    checks++;
    if ({pass_x, err_count_x} !== 4'b1_000) begin
      errors++;
      $display("FAIL xor_result: pass=%b cnt=%0d want 1,0", pass_x, err_count_x);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int done_seen;
    done_seen = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({dut_a, dut_b, busy, done, pass, err_count, err_vec} !== 10'd0) begin
      errors++;
      $display("FAIL midrun_reset: got %b want 0",
               {dut_a, dut_b, busy, done, pass, err_count, err_vec});
    end
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL midrun_no_done: activity=%0d pass=%b want 0,0", done_seen, pass);
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 6; k <= 11; k++) tick();
    start = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_first_done: busy,done=%b want 01", {busy, done});
    end
    tick();
    start = 1'b0;
    checks++;
    if ({busy, done, dut_a, dut_b} !== 4'b1000) begin
      errors++;
      $display("FAIL b2b_relaunch: busy,done,a,b=%b want 1000", {busy, done, dut_a, dut_b});
    end
    for (int k = 1; k <= 12; k++) tick();
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_second_pre: busy,done=%b want 10", {busy, done});
    end
    tick();
    checks++;
    if ({busy, done, pass} !== 3'b011) begin
      errors++;
      $display("FAIL b2b_second_done: busy,done,pass=%b want 011", {busy, done, pass});
    end
    tick();
  endtask

  task automatic test_err_then_clear();
    mode = 2;
    run_default("stuck3", 1, 3, 1'b0);
    mode = 0;
    run_default("recover", 0, 0, 1'b1);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    mode    = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    start_x = 1'b0;
    test_reset();
    test_and();
    test_or();
    test_xor_fast();
    test_reset_mid();
    test_back_to_back();
    test_err_then_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
